// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder:
//   - state_t        : FSM state encoding (IDLE / SHIFT / DONE)
//   - DEFAULT_WIDTH  : default operand width
//   - cnt_width()    : width of the bit counter for a given operand width
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  // Operand width used when the top is instantiated without overriding WIDTH.
  localparam int DEFAULT_WIDTH = 8;

  // Three-state control FSM; encoding is fixed so other blocks can decode it.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // The counter only has to reach WIDTH-1, so clog2(WIDTH) bits are enough.
  // A one-bit floor keeps the vector legal for degenerate widths.
  function automatic int cnt_width(input int w);
    int r;
    if (w < 2) begin
      r = 1;
    end else begin
      r = $clog2(w);
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_adder_seq_adder.sv
// -----------------------------------------------------------------------------
// serial_adder_seq_adder
// One-bit full-adder cell, used as the bit slice of the serial adder.
// Ports:
//   a, b  (in)  : operand bits
//   cin   (in)  : carry in
//   sum   (out) : a ^ b ^ cin
//   cout  (out) : majority(a, b, cin)
// -----------------------------------------------------------------------------
module serial_adder_seq_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_seq.sv
// -----------------------------------------------------------------------------
// serial_adder_seq
// Bit-serial adder: computes a_in + b_in + cin_in one bit per clock, LSB first,
// through a single full-adder slice.
// Ports:
//   clk      (in)        : clock, all state changes on the rising edge
//   rst      (in)        : synchronous active-high reset, overrides start
//   start    (in)        : load operands and begin an add (IDLE or DONE only)
//   a_in     (in, WIDTH) : operand A, captured on an accepted start
//   b_in     (in, WIDTH) : operand B, captured on an accepted start
//   cin_in   (in)        : initial carry, captured on an accepted start
//   busy     (out)       : high for the WIDTH cycles of SHIFT
//   done     (out)       : one-cycle pulse in DONE; results valid from then on
//   sum_out  (out, WIDTH): registered sum modulo 2^WIDTH, held until next DONE
//   cout_out (out)       : registered carry out of the MSB, held likewise
// Timing: start accepted in cycle 0 -> busy in cycles 1..WIDTH -> done in
// cycle WIDTH+1. All outputs come straight from flops.
// -----------------------------------------------------------------------------
module serial_adder_seq #(
  parameter int WIDTH = serial_adder_pkg::DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
);

  import serial_adder_pkg::*;

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             slice_sum;
  logic             slice_cout;
  logic [WIDTH-1:0] res_next;

  // Single bit slice; the carry register closes the ripple loop through time.
  serial_adder_seq_adder u_slice (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Result register after this cycle's shift: new bit enters at the MSB so
  // that after WIDTH shifts bit 0 of the sum sits at position 0.
  assign res_next = {slice_sum, res_sh[WIDTH-1:1]};

  // Control FSM plus all datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum_out  <= '0;
      cout_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh   <= a_in;
            b_sh   <= b_in;
            carry  <= cin_in;
            res_sh <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        SHIFT: begin
          // start is deliberately not looked at here: operands are frozen.
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_next;
          carry  <= slice_cout;
          if (cnt == LAST_BIT) begin
            // Last bit: publish the result on the same edge we enter DONE.
            sum_out  <= res_next;
            cout_out <= slice_cout;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            cnt   <= cnt + 1'b1;
            busy  <= 1'b1;
            done  <= 1'b0;
            state <= SHIFT;
          end
        end

        DONE: begin
          done <= 1'b0;
          if (start) begin
            // Back-to-back operation: reload without passing through IDLE.
            a_sh   <= a_in;
            b_sh   <= b_in;
            carry  <= cin_in;
            res_sh <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          // Unreachable encoding: recover quietly to IDLE.
          busy  <= 1'b0;
          done  <= 1'b0;
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_seq.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_seq
// Directed self-checking bench for serial_adder_seq with WIDTH=8.
// Inputs are driven 1 time unit after the rising edge and outputs are sampled
// at the same point, so "cycle n" is the interval following the n-th edge.
// -----------------------------------------------------------------------------
module tb_serial_adder_seq;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum_out;
  logic         cout_out;

  int checks;
  int errors;

  serial_adder_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .cin_in   (cin_in),
    .busy     (busy),
    .done     (done),
    .sum_out  (sum_out),
    .cout_out (cout_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Start an add in the current cycle, verify busy/done timing for cycles
  // 1..WIDTH+1, the result in the done cycle, and that it holds afterwards.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic [8:0] exp);
    a_in   = a;
    b_in   = b;
    cin_in = c;
    start  = 1'b1;
    step();
    start  = 1'b0;
    a_in   = ~a;           // must not disturb the operation in flight
    b_in   = ~b;
    cin_in = ~c;
    for (int cyc = 1; cyc <= W; cyc++) begin
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      check({tag, "_nodone"}, {31'd0, done}, 32'd0);
      step();
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_busy_lo"}, {31'd0, busy}, 32'd0);
    check({tag, "_result"}, {23'd0, cout_out, sum_out}, {23'd0, exp});
    step();
    check({tag, "_done_lo"}, {31'd0, done}, 32'd0);
    check({tag, "_hold"}, {23'd0, cout_out, sum_out}, {23'd0, exp});
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    logic [8:0] rexp;
    int         ndone;

    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b1;          // reset must win over start
    a_in   = 8'h5A;
    b_in   = 8'hA5;
    cin_in = 1'b1;
    step();
    step();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum", {24'd0, sum_out}, 32'd0);
    check("rst_cout", {31'd0, cout_out}, 32'd0);
    start = 1'b0;
    rst   = 1'b0;
    step();
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Basic add and carry cases.
    run_op("basic", 8'h0F, 8'h01, 1'b0, 9'h010);
    run_op("cout1", 8'hFF, 8'h01, 1'b0, 9'h100);
    run_op("cout2", 8'hFF, 8'hFF, 1'b1, 9'h1FF);
    run_op("cinonly", 8'h00, 8'h00, 1'b1, 9'h001);
    run_op("alt", 8'hAA, 8'h55, 1'b1, 9'h100);

    // Start while busy is ignored.
    a_in   = 8'h12;
    b_in   = 8'h34;
    cin_in = 1'b0;
    start  = 1'b1;
    step();                 // cycle 1
    start  = 1'b0;
    ndone  = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (cyc == 4) begin
        start = 1'b1;
        a_in  = 8'hFF;
      end else begin
        start = 1'b0;
      end
      if (cyc == 9) begin
        check("ign_done9", {31'd0, done}, 32'd1);
        check("ign_sum", {23'd0, cout_out, sum_out}, 32'h046);
      end
      if (done) ndone++;
      step();
    end
    check("ign_single_done", ndone, 32'd1);

    // Reset in the middle of an operation.
    a_in   = 8'hAA;
    b_in   = 8'h55;
    cin_in = 1'b0;
    start  = 1'b1;
    step();                 // cycle 1
    start  = 1'b0;
    step();
    step();
    step();                 // cycle 4
    rst = 1'b1;
    step();                 // cycle 5
    rst = 1'b0;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_out", {23'd0, cout_out, sum_out}, 32'd0);
    run_op("after_rst", 8'h01, 8'h02, 1'b0, 9'h003);

    // Back-to-back with start held high.
    a_in   = 8'h0F;
    b_in   = 8'h01;
    cin_in = 1'b0;
    start  = 1'b1;
    for (int cyc = 1; cyc <= 19; cyc++) begin
      step();
      if (cyc == 9 || cyc == 18) begin
        check("b2b_done", {31'd0, done}, 32'd1);
        check("b2b_busy_lo", {31'd0, busy}, 32'd0);
      end else if (cyc == 19) begin
        check("b2b_idle_busy", {31'd0, busy}, 32'd0);
        check("b2b_idle_done", {31'd0, done}, 32'd0);
      end else begin
        check("b2b_busy", {31'd0, busy}, 32'd1);
        check("b2b_nodone", {31'd0, done}, 32'd0);
      end
      if (cyc == 9) begin
        check("b2b_res1", {23'd0, cout_out, sum_out}, 32'h010);
        a_in   = 8'h80;
        b_in   = 8'h80;
        cin_in = 1'b1;
      end
      if (cyc == 18) begin
        check("b2b_res2", {23'd0, cout_out, sum_out}, 32'h101);
        start = 1'b0;
      end
    end

    // Random operands against integer addition.
    for (int n = 0; n < 1000; n++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rc   = 1'($urandom);
      rexp = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      run_op("rand", ra, rb, rc, rexp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder_seq.md
SERIAL_ADDER_SEQ -- requirements
Module: serial_adder_seq

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to add the current a_in, b_in and cin_in.
REQ-005 a_in  input  WIDTH  operand A, sampled only on an accepted start.
REQ-006 b_in  input  WIDTH  operand B, sampled only on an accepted start.
REQ-007 cin_in  input  1  initial carry, sampled only on an accepted start.
REQ-008 busy  output  1  high while bits are being processed.
REQ-009 done  output  1  one-cycle pulse; sum_out and cout_out are valid from this cycle.
REQ-010 sum_out  output  WIDTH  registered result A+B+cin modulo 2^WIDTH.
REQ-011 cout_out  output  1  registered carry out of bit WIDTH-1.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-013 In IDLE with start=1, the block SHALL load a_in, b_in and cin_in into shift and carry registers, clear the bit counter, and enter SHIFT.
REQ-014 In SHIFT, each cycle the block SHALL feed the LSBs of the A/B shift registers and the carry register into one full-adder bit slice, shift both operand registers right by one, shift the slice sum into the MSB of the result register, and register the slice cout as the next carry.
REQ-015 SHIFT SHALL last exactly WIDTH cycles; after the cycle with counter = WIDTH-1 the FSM SHALL enter DONE.
REQ-016 On the DONE entry edge, sum_out SHALL take the full result register and cout_out SHALL take the final carry.
REQ-017 DONE SHALL last one cycle with done=1; the FSM SHALL then go to IDLE, or to SHIFT if start=1 in that cycle (back-to-back load per REQ-013).
REQ-018 Latency: start accepted in cycle 0 -> busy=1 in cycles 1..WIDTH -> done=1 in cycle WIDTH+1.
REQ-019 start in SHIFT SHALL be ignored; operands SHALL not change mid-operation.
REQ-020 sum_out and cout_out SHALL hold their last values until the next DONE entry.
REQ-021 busy SHALL be 1 only in SHIFT; done SHALL be 1 only in DONE.
REQ-022 The bit counter SHALL be clog2(WIDTH) bits wide (minimum 1) and SHALL not wrap during an operation.

Reset
REQ-023 With rst=1 at a clock edge, the FSM SHALL go to IDLE and busy, done, sum_out, cout_out, the carry, the counter and the shift registers SHALL all clear to 0.
REQ-024 rst SHALL take priority over start in the same cycle.
REQ-025 Reset mid-SHIFT SHALL abandon the operation with no done pulse; a start in the first cycle after rst deasserts SHALL be accepted.

Structure
REQ-026 A shared package serial_adder_pkg SHALL hold the state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the default WIDTH constant.
REQ-027 The bit slice SHALL be one instance of the team's ADDER full-adder cell (a, b, cin -> sum, cout); this is the only sub-module, and the carry register SHALL feed its cin.
REQ-028 No combinational path SHALL exist from any input to any output.

Verification (WIDTH=8)
REQ-029 Basic add: start with A=0x0F, B=0x01, cin=0 in cycle 0 -> busy in cycles 1..8, done in cycle 9, sum_out=0x10, cout_out=0.
REQ-030 Carry out: A=0xFF, B=0x01, cin=0 -> sum_out=0x00, cout_out=1; then A=0xFF, B=0xFF, cin=1 -> sum_out=0xFF, cout_out=1.
REQ-031 Start ignored while busy: A=0x12, B=0x34 accepted; start with A=0xFF pulsed in cycle 4 -> single done in cycle 9, sum_out=0x46, and no further done.
REQ-032 Reset mid-operation: start A=0xAA, B=0x55; rst in cycle 4 -> outputs all 0, no done; start with A=0x01, B=0x02 next cycle -> sum_out=0x03 after 9 cycles.
REQ-033 Back-to-back: start held high -> done in cycles 9 and 18, busy low only in cycles 9 and 18, and the results from both operations are correct.
REQ-034 Random: 1000 random A, B and cin values -> {cout_out, sum_out} equals A+B+cin for every operation.
